// File: rtl/if_stage.sv
// ============================================================================
// Module  : if_stage
// Brief   : RV32I instruction-fetch stage; owns the PC, drives imem and fills
//           the IF/ID register. Optional feature macro: IF_MISALIGN_TRAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        fetch_fault
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ID_HOLD   = 2'd0,
        ID_LOAD   = 2'd1,
        ID_BUBBLE = 2'd2
    } id_op_t;

    state_t      r_state;
    state_t      w_state_nxt;
    id_op_t      w_id_op;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pc_plus4;
    logic        w_redir_aligned;

    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;

    assign imem_addr       = r_pc;
    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_redir_aligned = (redirect_pc[1:0] == 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_id_op     = ID_HOLD;
        case (r_state)
            ST_RUN: begin
                if (redirect) begin
                    w_id_op = ID_BUBBLE;
`ifdef IF_MISALIGN_TRAP_EN
                    if (w_redir_aligned) begin
                        w_pc_nxt = redirect_pc;
                    end else begin
                        w_state_nxt = ST_FAULT;
                    end
`else
                    w_pc_nxt = {redirect_pc[31:2], 2'b00};
`endif
                end else if (stall) begin
                    w_id_op = flush ? ID_BUBBLE : ID_HOLD;
                end else begin
                    w_pc_nxt = w_pc_plus4;
                    w_id_op  = flush ? ID_BUBBLE : ID_LOAD;
                end
            end
            ST_FAULT: begin
                // Parked until software redirects to an aligned target.
                w_id_op = ID_BUBBLE;
                if (redirect && w_redir_aligned) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
            r_id_pc    <= 32'd0;
            r_id_pc4   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            case (w_id_op)
                ID_LOAD: begin
                    r_id_valid <= 1'b1;
                    r_id_instr <= imem_data;
                    r_id_pc    <= r_pc;
                    r_id_pc4   <= w_pc_plus4;
                end
                ID_BUBBLE: begin
                    r_id_valid <= 1'b0;
                    r_id_instr <= NOP_INSTR;
                end
                default: begin
                end
            endcase
        end
    end

    assign id_valid = r_id_valid;
    assign id_instr = r_id_instr;
    assign id_pc    = r_id_pc;
    assign id_pc4   = r_id_pc4;

`ifdef IF_MISALIGN_TRAP_EN
    assign fetch_fault = (r_state == ST_FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module  : tb_if_stage
// Brief   : Self-checking bench for if_stage using a reference model and an
//           expected-result queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] C_NOP    = 32'h0000_0013;
    localparam logic [31:0] C_WRAPPC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, redirect;
    logic [31:0] redirect_pc;

    logic [31:0] imem_addr, imem_data, id_instr, id_pc, id_pc4;
    logic        id_valid, fetch_fault;

    logic [31:0] w_imem_addr, w_imem_data, w_id_instr, w_id_pc, w_id_pc4;
    logic        w_id_valid, w_fetch_fault;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    assign imem_data   = imem_word(imem_addr);
    assign w_imem_data = imem_word(w_imem_addr);

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc4(id_pc4), .fetch_fault(fetch_fault)
    );

    if_stage #(.RESET_PC(C_WRAPPC)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(w_imem_addr), .imem_data(w_imem_data),
        .id_valid(w_id_valid), .id_instr(w_id_instr), .id_pc(w_id_pc),
        .id_pc4(w_id_pc4), .fetch_fault(w_fetch_fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] idpc;
        logic [31:0] idpc4;
        logic        fault;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_pc, m_instr, m_idpc, m_idpc4;
    logic        m_valid, m_fault;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", tag, got, exp);
    endtask

    // Spec-level prediction of the state after the coming edge.
    task automatic predict();
        exp_t e;
        e.pc = m_pc; e.valid = m_valid; e.instr = m_instr;
        e.idpc = m_idpc; e.idpc4 = m_idpc4; e.fault = m_fault;
        if (rst) begin
            e.pc = 32'd0; e.valid = 1'b0; e.instr = C_NOP;
            e.idpc = 32'd0; e.idpc4 = 32'd0; e.fault = 1'b0;
        end else if (m_fault) begin
            e.valid = 1'b0; e.instr = C_NOP;
            if (redirect && redirect_pc[1:0] == 2'b00) begin
                e.pc = redirect_pc; e.fault = 1'b0;
            end
        end else if (redirect) begin
            e.valid = 1'b0; e.instr = C_NOP;
`ifdef IF_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) e.fault = 1'b1;
            else                           e.pc = redirect_pc;
`else
            e.pc = {redirect_pc[31:2], 2'b00};
`endif
        end else begin
            if (!stall) e.pc = m_pc + 32'd4;
            if (flush) begin
                e.valid = 1'b0; e.instr = C_NOP;
            end else if (!stall) begin
                e.valid = 1'b1; e.instr = imem_word(m_pc);
                e.idpc = m_pc; e.idpc4 = m_pc + 32'd4;
            end
        end
        q.push_back(e);
        m_pc = e.pc; m_valid = e.valid; m_instr = e.instr;
        m_idpc = e.idpc; m_idpc4 = e.idpc4; m_fault = e.fault;
    endtask

    task automatic step();
        exp_t e;
        predict();
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("imem_addr",   imem_addr,          e.pc);
        chk("id_valid",    {31'd0, id_valid},  {31'd0, e.valid});
        chk("id_instr",    id_instr,           e.instr);
        chk("id_pc",       id_pc,              e.idpc);
        chk("id_pc4",      id_pc4,             e.idpc4);
        chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
    endtask

    task automatic idle();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    endtask

    initial begin
        logic [7:0] t_hi;
        logic [1:0] t_lo;
        m_pc = 32'd0; m_valid = 1'b0; m_instr = C_NOP;
        m_idpc = 32'd0; m_idpc4 = 32'd0; m_fault = 1'b0;
        idle();
        rst = 1'b1;
        #1;
        step(); step();
        chk("wrap_reset_addr", w_imem_addr, C_WRAPPC);
        rst = 1'b0;

        // Free run, then a 3-cycle stall with PC at 8.
        step();
        chk("wrap_addr1", w_imem_addr, 32'hFFFF_FFFC);
        chk("wrap_idpc1", w_id_pc, 32'hFFFF_FFF8);
        step();
        chk("wrap_addr2", w_imem_addr, 32'h0000_0000);
        chk("wrap_idpc2", w_id_pc, 32'hFFFF_FFFC);
        chk("wrap_idpc4_2", w_id_pc4, 32'h0000_0000);
        chk("pc_at_8", imem_addr, 32'd8);
        stall = 1'b1;
        repeat (3) step();
        chk("stall_addr", imem_addr, 32'd8);
        chk("stall_idpc", id_pc, 32'd4);
        stall = 1'b0;
        repeat (3) step();
        chk("resume_idpc", id_pc, 32'd16);

        // Redirect together with stall.
        redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
        step();
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_bubble", id_instr, C_NOP);
        idle();
        step();
        chk("redir_idpc", id_pc, 32'h40);

        // Flush alone.
        flush = 1'b1;
        step();
        chk("flush_valid", {31'd0, id_valid}, 32'd0);
        idle();
        step();

        // Misaligned redirect.
        redirect = 1'b1; redirect_pc = 32'h42;
        step();
`ifdef IF_MISALIGN_TRAP_EN
        chk("misalign_fault", {31'd0, fetch_fault}, 32'd1);
`else
        chk("misalign_addr", imem_addr, 32'h40);
`endif
        idle();
        flush = 1'b1; stall = 1'b1;
        repeat (2) step();
        idle();
        redirect = 1'b1; redirect_pc = 32'h44;
        step();
        idle();
        step();
        chk("recover_idpc", id_pc, 32'h44);

        // Reset while faulted/stalled.
        redirect = 1'b1; redirect_pc = 32'h83;
        step();
        idle();
        stall = 1'b1; rst = 1'b1;
        step();
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        idle();
        repeat (2) step();

        // Random mix.
        for (int i = 0; i < 60; i++) begin
            t_hi        = 8'($urandom_range(0, 255));
            t_lo        = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rst         = ($urandom_range(0, 29) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 5) == 0);
            redirect    = ($urandom_range(0, 5) == 0);
            redirect_pc = {22'd0, t_hi, t_lo};
            step();
        end
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
